main_memory_ctrl: RTL and testbench
===================================

// Module: main_memory_ctrl
// PURPOSE
//   Clocked main-memory model sitting directly downstream of the cache blocks.
//   It serves block reads (128-bit refill) and write-through single-word writes with a programmable latency.
//   It uses a request/ready handshake. The request is isLock low, sampled on clk.
// PARAMETERS
//   LATENCY  4   cycles from request acceptance to completion; legal range 1..15
// PORTS
//   clk            in   1    system clock, rising-edge
//   reset          in   1    asynchronous, active-high reset
//   isLock         in   1    request, active low; level-held by the cache until it sees isReady
//   isMemRead      in   1    1 = block read, 0 = word write
//   address        in   10   byte address; [9:4] block index, [3:2] word offset, [1:0] ignored
//   memWriteData   in   128  write data; only [31:0] is used
//   memReadData    out  128  refill block; word 0 is in [127:96] and word 3 is in [31:0]
//   isReady        out  1    one-cycle completion pulse
//   isBusy         out  1    high while a request is accepted and not yet completed
// BEHAVIOUR
//   Storage
//   - 64 x 128-bit array (1 KiB).
//   - Loaded once at time 0: the word at byte address a = {22'b0, a}.
//   - Reset does not alter the array contents.
//   Reset (async)
//   - state = IDLE, cnt = 0.
//   - memReadData = 0, isReady = 0, isBusy = 0.
//   - Reset mid-operation aborts the request; a pending write is NOT committed.
//   FSM states: IDLE, BUSY, RESP, RELEASE.
//   IDLE
//   - If isLock == 0 at a clk edge: latch address, isMemRead and memWriteData[31:0].
//   - Set cnt = LATENCY-1, isBusy = 1, go to BUSY.
//   - Otherwise stay in IDLE.
//   BUSY
//   - While cnt != 0: cnt decrements each edge.
//   - At the edge where cnt == 0, the operation commits and the FSM goes to RESP:
//     - read: memReadData <= array[addr[9:4]].
//     - write: the word at addr[3:2] of array[addr[9:4]] <= latched data; the other 3 words are unchanged.
//     - isReady <= 1, isBusy <= 0.
//   - Inputs are ignored in BUSY: a request is committed once latched, even if isLock rises mid-BUSY.
//   RESP
//   - Lasts exactly one cycle; isReady is deasserted on leaving.
//   - If isLock == 1, go to IDLE; else go to RELEASE.
//   RELEASE
//   - Waits for isLock == 1, then goes to IDLE.
//   - This stops a held-low isLock from re-triggering the same request.
//   Timing
//   - Request sampled at edge N: commit and isReady rise at edge N+LATENCY; isReady falls at edge N+LATENCY+1.
//   - Earliest next acceptance is edge N+LATENCY+2, provided isLock is high at N+LATENCY+1 and low at N+LATENCY+2.
//   Outputs
//   - memReadData holds its value until the next read commit; writes never change it.
//   - isMemRead and address changes outside IDLE acceptance have no effect.
// TESTING
//   1) Reset with LATENCY=4, isLock=1 for 5 cycles -> isReady=0, isBusy=0, memReadData=0.
//   2) Read address 10'h010 accepted at edge N ->
//      - isBusy high N..N+4;
//      - isReady pulses at N+4 only;
//      - memReadData = {32'h10, 32'h14, 32'h18, 32'h1C}.
//   3) Write 32'hDEADBEEF to address 10'h01C, then read 10'h010 ->
//      memReadData = {32'h10, 32'h14, 32'h18, 32'hDEADBEEF}.
//   4) Keep isLock low for 10 cycles after a single read ->
//      - exactly one isReady pulse;
//      - FSM held in RELEASE;
//      - a new request is accepted only after isLock returns high.
//   5) Assert reset 2 cycles into a write to 10'h000 ->
//      - isBusy=0 immediately;
//      - no isReady;
//      - a subsequent read of 10'h000 returns word 0 = 32'h0.
//   6) LATENCY=1, back-to-back reads of 10'h3F0 and 10'h000 ->
//      - each isReady pulse arrives one edge after acceptance;
//      - data = {32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC}, then {32'h0, 32'h4, 32'h8, 32'hC}.

Source files
------------

// File: rtl/main_memory_ctrl.sv
// Clocked 1 KiB main memory behind the caches: 128-bit block refills and write-through
// single-word writes, completed a fixed LATENCY cycles after the request is accepted.
module main_memory_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         isLock,
    input  logic         isMemRead,
    input  logic [9:0]   address,
    input  logic [127:0] memWriteData,
    output logic [127:0] memReadData,
    output logic         isReady,
    output logic         isBusy,
    output logic [1:0]   dbgState
);

    // Handshake: a request is isLock low at a clk edge while IDLE; the cache holds it low
    // until it sees the one-cycle isReady pulse, and must return it high before the next
    // request is accepted (RELEASE absorbs a lock that stays low after completion).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef logic [127:0] memArr_t [64];

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    // Power-up image: the word at byte address a holds the value a.
    function automatic memArr_t initMem();
        memArr_t m;
        for (int b = 0; b < 64; b++) begin
            for (int w = 0; w < 4; w++) begin
                m[6'(b)][(127 - 32 * w) -: 32] = 32'(b * 16 + w * 4);
            end
        end
        return m;
    endfunction

    memArr_t mem = initMem();

    state_t      state;
    state_t      nextState;
    logic [3:0]  cnt;
    logic [9:0]  latAddr;
    logic        latRead;
    logic [31:0] latData;
    logic        commit;

    assign dbgState = state;
    assign commit   = (state == BUSY) && (cnt == 4'd0);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!isLock) nextState = BUSY;
            BUSY:    if (cnt == 4'd0) nextState = RESP;
            RESP:    nextState = isLock ? IDLE : RELEASE;
            RELEASE: if (isLock) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            latAddr     <= 10'd0;
            latRead     <= 1'b0;
            latData     <= 32'd0;
            memReadData <= 128'd0;
            isReady     <= 1'b0;
            isBusy      <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (!isLock) begin
                        latAddr <= address;
                        latRead <= isMemRead;
                        latData <= memWriteData[31:0];
                        cnt     <= CNT_INIT;
                        isBusy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (latRead) memReadData <= mem[latAddr[9:4]];
                        isReady <= 1'b1;
                        isBusy  <= 1'b0;
                    end
                end
                RESP:    isReady <= 1'b0;
                default: ;
            endcase
        end
    end

    // The array is kept out of the reset domain; an aborted write never reaches commit
    // because reset forces the FSM back to IDLE asynchronously.
    always_ff @(posedge clk) begin
        if (commit && !latRead) begin
            case (latAddr[3:2])
                2'd0: mem[latAddr[9:4]][127:96] <= latData;
                2'd1: mem[latAddr[9:4]][95:64]  <= latData;
                2'd2: mem[latAddr[9:4]][63:32]  <= latData;
                2'd3: mem[latAddr[9:4]][31:0]   <= latData;
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: two instances (LATENCY 4 and 1) driven by directed and random
// requests, checked against a word-array reference memory kept in the bench.
module tb_main_memory_ctrl;

    logic         clk;
    logic         reset;
    logic         isMemRead;
    logic [9:0]   address;
    logic [127:0] memWriteData;
    logic         lock4, lock1;
    logic [127:0] rd4, rd1;
    logic         rdy4, rdy1, busy4, busy1;
    logic [1:0]   st4, st1;

    main_memory_ctrl #(.LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .isLock(lock4), .isMemRead(isMemRead), .address(address),
        .memWriteData(memWriteData), .memReadData(rd4), .isReady(rdy4), .isBusy(busy4),
        .dbgState(st4)
    );

    main_memory_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .isLock(lock1), .isMemRead(isMemRead), .address(address),
        .memWriteData(memWriteData), .memReadData(rd1), .isReady(rdy1), .isBusy(busy1),
        .dbgState(st1)
    );

    // dbgState encoding as exported by the design
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nErr   = 0;
    int nChecks = 0;
    int sel    = 0;

    logic [127:0] obsData;
    logic         obsRdy, obsBusy;
    logic [1:0]   obsSt;
    assign obsData = (sel == 1) ? rd1   : rd4;
    assign obsRdy  = (sel == 1) ? rdy1  : rdy4;
    assign obsBusy = (sel == 1) ? busy1 : busy4;
    assign obsSt   = (sel == 1) ? st1   : st4;

    logic [31:0]  refMem [2][64][4];
    logic [127:0] lastRd [2];

    function automatic logic [127:0] expBlock(input int s, input logic [5:0] b);
        return {refMem[s][b][0], refMem[s][b][1], refMem[s][b][2], refMem[s][b][3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setLock(input logic v);
        if (sel == 1) lock1 = v;
        else lock4 = v;
    endtask

    // One complete request with the lock released right after the completion pulse.
    task automatic doReq(input logic rd, input logic [9:0] a, input logic [31:0] d,
                         input int lat, input logic wiggle, input string tag);
        @(negedge clk);
        isMemRead    = rd;
        address      = a;
        memWriteData = {$urandom, $urandom, $urandom, d};
        setLock(1'b0);
        @(posedge clk); #1;
        chk($sformatf("%s busy_at_accept", tag), 128'(obsBusy), 128'(1'b1));
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (wiggle) begin
                isMemRead = 1'($urandom);
                address   = 10'($urandom);
                if ($urandom_range(0, 3) == 0) setLock(1'b1);
            end
            @(posedge clk); #1;
            chk($sformatf("%s ready_k%0d", tag, k), 128'(obsRdy), 128'(k == lat));
            chk($sformatf("%s busy_k%0d", tag, k), 128'(obsBusy), 128'(k != lat));
        end
        if (rd) lastRd[sel] = expBlock(sel, a[9:4]);
        else refMem[sel][a[9:4]][a[3:2]] = d;
        chk($sformatf("%s data", tag), obsData, lastRd[sel]);
        @(negedge clk);
        setLock(1'b1);
        @(posedge clk); #1;
        chk($sformatf("%s ready_drop", tag), 128'(obsRdy), 128'(1'b0));
        chk($sformatf("%s idle", tag), 128'(obsSt), 128'(ST_IDLE));
    endtask

    initial begin
        int pulses;
        int pulseAt;
        logic [31:0] wd;

        for (int s = 0; s < 2; s++) begin
            lastRd[s] = '0;
            for (int b = 0; b < 64; b++)
                for (int w = 0; w < 4; w++)
                    refMem[s][b][w] = 32'(b * 16 + w * 4);
        end

        // Reset with the lock idle
        reset = 1'b1; lock4 = 1'b1; lock1 = 1'b1;
        isMemRead = 1'b0; address = '0; memWriteData = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset ready4", 128'(rdy4), 128'(1'b0));
        chk("reset busy4", 128'(busy4), 128'(1'b0));
        chk("reset data4", rd4, 128'd0);
        chk("reset ready1", 128'(rdy1), 128'(1'b0));
        chk("reset data1", rd1, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Plain block read
        sel = 0;
        doReq(1'b1, 10'h010, 32'h0, 4, 1'b0, "read010");
        chk("read010 literal", rd4, {32'h10, 32'h14, 32'h18, 32'h1C});

        // Write-through of word 3, then refill of the same block
        doReq(1'b0, 10'h01C, 32'hDEADBEEF, 4, 1'b0, "write01C");
        doReq(1'b1, 10'h010, 32'h0, 4, 1'b0, "reread010");
        chk("reread010 literal", rd4, {32'h10, 32'h14, 32'h18, 32'hDEADBEEF});

        // Lock held low long after completion: one pulse, parked in RELEASE
        @(negedge clk);
        isMemRead = 1'b1; address = 10'h020; lock4 = 1'b0;
        @(posedge clk);
        pulses = 0; pulseAt = -1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (rdy4) begin pulses++; pulseAt = k; end
        end
        lastRd[0] = expBlock(0, 6'h02);
        chk("held pulses", 128'(pulses), 128'd1);
        chk("held pulse_edge", 128'(pulseAt), 128'd4);
        chk("held busy", 128'(busy4), 128'(1'b0));
        chk("held release", 128'(st4), 128'(ST_RELEASE));
        chk("held data", rd4, lastRd[0]);
        @(negedge clk); lock4 = 1'b1;
        @(posedge clk); #1;
        chk("held back_idle", 128'(st4), 128'(ST_IDLE));
        doReq(1'b1, 10'h030, 32'h0, 4, 1'b0, "after_release");

        // Reset two cycles into a write: aborted, nothing committed
        wd = $urandom;
        @(negedge clk);
        isMemRead = 1'b0; address = 10'h000; memWriteData = {96'd0, wd}; lock4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        chk("abort busy", 128'(busy4), 128'(1'b0));
        chk("abort ready", 128'(rdy4), 128'(1'b0));
        chk("abort data", rd4, 128'd0);
        lastRd[0] = '0; lastRd[1] = '0;
        @(negedge clk); lock4 = 1'b1;
        @(negedge clk); reset = 1'b0;
        doReq(1'b1, 10'h000, 32'h0, 4, 1'b0, "after_abort");
        chk("after_abort word0", 128'(rd4[127:96]), 128'd0);

        // Minimum latency, back-to-back reads at the ends of the array
        sel = 1;
        doReq(1'b1, 10'h3F0, 32'h0, 1, 1'b0, "lat1_3F0");
        chk("lat1_3F0 literal", rd1, {32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC});
        doReq(1'b1, 10'h000, 32'h0, 1, 1'b0, "lat1_000");
        chk("lat1_000 literal", rd1, {32'h0, 32'h4, 32'h8, 32'hC});

        // Random mix with inputs disturbed while busy
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 1));
            doReq(1'($urandom), 10'($urandom_range(0, 1023)), $urandom,
                  (sel == 1) ? 1 : 4, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
